// File: rtl/i2c_ram_arb_pkg.sv
// Shared types for the I2C/host RAM arbiter: grant encoding and default widths.
// Latency: n/a (types only).
// Backpressure: n/a.
package i2c_ram_arb_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I2C  = 2'd1,
    GNT_HOST = 2'd2
  } gnt_e;

endpackage

// File: rtl/i2c_req_buf.sv
// One-entry holding register for I2C accesses that lost arbitration.
// Latency: an entry loaded at edge T is servable from cycle T+1.
// Backpressure: none upstream; a live request arriving while full is dropped and ovf latches.
module i2c_req_buf
  import i2c_ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          live_req,
  input  logic          live_we,
  input  logic [AW-1:0] live_addr,
  input  logic [DW-1:0] live_wdata,
  input  logic          live_taken,
  input  logic          pop,
  output logic          buf_vld,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [DW-1:0] buf_wdata,
  output logic          ovf
);

  logic free;
  logic load;
  logic drop;

  // A live pulse not consumed by bypass goes into the slot if it is empty or being freed
  always_comb begin
    free = pop | ~buf_vld;
    load = live_req & ~live_taken & free;
    drop = live_req & ~live_taken & ~free;
  end

  // Slot contents, valid flag and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld   <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      ovf       <= 1'b0;
    end else begin
      if (load) begin
        buf_vld   <= 1'b1;
        buf_we    <= live_we;
        buf_addr  <= live_addr;
        buf_wdata <= live_wdata;
      end else if (pop) begin
        buf_vld <= 1'b0;
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_ram_arb.sv
// Arbitrates the single-port register RAM between the I2C slave and a host req/ack port.
// Latency: access granted in cycle T completes (rvalid/ack) in T+1; host waits at most MAX_WAIT+1 cycles.
// Backpressure: I2C never stalls (one-deep buffer, sticky overflow); host holds h_req until h_ack.
module i2c_ram_arb
  import i2c_ram_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2c_req,
  input  logic          i2c_we,
  input  logic [AW-1:0] i2c_addr,
  input  logic [DW-1:0] i2c_wdata,
  output logic [DW-1:0] i2c_rdata,
  output logic          i2c_rvalid,
  output logic          i2c_ovf,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  gnt_e          gnt;
  gnt_e          gnt_q;
  logic          rd_q;
  logic [3:0]    wait_cnt;
  logic          buf_vld;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;
  logic          i2c_pend;
  logic          host_pend;
  logic          live_taken;
  logic          buf_pop;

  i2c_req_buf #(
    .AW(AW),
    .DW(DW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .live_req   (i2c_req),
    .live_we    (i2c_we),
    .live_addr  (i2c_addr),
    .live_wdata (i2c_wdata),
    .live_taken (live_taken),
    .pop        (buf_pop),
    .buf_vld    (buf_vld),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .ovf        (i2c_ovf)
  );

  // The ack cycle itself never counts as host demand, so a held h_req is not re-granted
  assign i2c_pend  = buf_vld | i2c_req;
  assign host_pend = h_req & ~h_ack;

  // Grant decision: I2C first unless the host has been denied MAX_WAIT cycles
  always_comb begin
    gnt = GNT_NONE;
    if (host_pend && (wait_cnt == MAX_W)) begin
      gnt = GNT_HOST;
    end else if (i2c_pend) begin
      gnt = GNT_I2C;
    end else if (host_pend) begin
      gnt = GNT_HOST;
    end
  end

  // RAM port mux; the buffered entry is older than the live pulse so it goes first
  always_comb begin
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    live_taken = 1'b0;
    buf_pop    = 1'b0;
    case (gnt)
      GNT_I2C: begin
        if (buf_vld) begin
          ram_we   = buf_we;
          ram_addr = buf_addr;
          ram_din  = buf_wdata;
          buf_pop  = 1'b1;
        end else begin
          ram_we     = i2c_we;
          ram_addr   = i2c_addr;
          ram_din    = i2c_wdata;
          live_taken = 1'b1;
        end
      end
      GNT_HOST: begin
        ram_we   = h_we;
        ram_addr = h_addr;
        ram_din  = h_wdata;
      end
      default: ;
    endcase
  end

  // Registered grant copy drives the completion strobes one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q <= GNT_NONE;
      rd_q  <= 1'b0;
    end else begin
      gnt_q <= gnt;
      rd_q  <= (gnt != GNT_NONE) && !ram_we;
    end
  end

  assign i2c_rvalid = (gnt_q == GNT_I2C) && rd_q;
  assign h_ack      = (gnt_q == GNT_HOST);

  // Capture read data at the end of the grant cycle; hold otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i2c_rdata <= '0;
      h_rdata   <= '0;
    end else begin
      if (gnt == GNT_I2C && !ram_we) begin
        i2c_rdata <= ram_dout;
      end
      if (gnt == GNT_HOST && !ram_we) begin
        h_rdata <= ram_dout;
      end
    end
  end

  // Starvation counter: counts denied host cycles, saturating at MAX_WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!h_req || gnt == GNT_HOST) begin
      wait_cnt <= '0;
    end else if (host_pend && wait_cnt != MAX_W) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_i2c_ram_arb.sv
// Randomised and directed bench for i2c_ram_arb against a queue-based reference model.
// Latency: checks completion strobes one cycle after each modelled grant.
// Backpressure: host driver holds h_req until ack, then drops or re-issues.
module tb_i2c_ram_arb;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i2c_req, i2c_we;
  logic [AW-1:0] i2c_addr;
  logic [DW-1:0] i2c_wdata;
  logic [DW-1:0] i2c_rdata;
  logic          i2c_rvalid, i2c_ovf;
  logic          h_req, h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_ack;
  logic [DW-1:0] h_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  i2c_ram_arb #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_rdata(i2c_rdata), .i2c_rvalid(i2c_rvalid), .i2c_ovf(i2c_ovf),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM instance stand-in: combinational read, write on rising edge
  logic [DW-1:0] mem [32];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  // Reference model state
  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  logic [DW-1:0] mm [32];
  op_t           bq[$];
  int            wcnt;
  logic          e_rv, e_ack, e_ovf;
  logic [DW-1:0] e_rd, e_hrd;
  logic          ack_was;
  int            errs = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    wcnt  = 0;
    e_rv  = 1'b0;
    e_ack = 1'b0;
    e_ovf = 1'b0;
    e_rd  = '0;
    e_hrd = '0;
  endtask

  // One clock cycle: check registered outputs, predict this cycle's RAM access, advance model
  task automatic step();
    op_t  live, hop, win;
    int   who;
    logic hp, live_used;
    #1;
    chk("i2c_rvalid", 32'(i2c_rvalid), 32'(e_rv));
    chk("i2c_rdata", 32'(i2c_rdata), 32'(e_rd));
    chk("h_ack", 32'(h_ack), 32'(e_ack));
    chk("h_rdata", 32'(h_rdata), 32'(e_hrd));
    chk("i2c_ovf", 32'(i2c_ovf), 32'(e_ovf));
    ack_was = e_ack;
    live.we = i2c_we; live.a = i2c_addr; live.d = i2c_wdata;
    hop.we  = h_we;   hop.a  = h_addr;   hop.d  = h_wdata;
    hp = h_req && !e_ack;
    who = 0;
    if (hp && wcnt >= MAX_WAIT) who = 2;
    else if (bq.size() > 0 || i2c_req) who = 1;
    else if (hp) who = 2;
    win = '0;
    live_used = 1'b0;
    if (who == 1) begin
      if (bq.size() > 0) win = bq.pop_front();
      else begin
        win = live;
        live_used = 1'b1;
      end
    end else if (who == 2) begin
      win = hop;
    end
    if (i2c_req && !live_used) begin
      if (bq.size() == 0) bq.push_back(live);
      else e_ovf = 1'b1;
    end
    chk("ram_we", 32'(ram_we), 32'(win.we));
    chk("ram_addr", 32'(ram_addr), 32'(win.a));
    chk("ram_din", 32'(ram_din), 32'(win.d));
    e_rv  = (who == 1) && !win.we;
    e_ack = (who == 2);
    if (who != 0) begin
      if (win.we) mm[win.a] = win.d;
      else if (who == 1) e_rd = mm[win.a];
      else e_hrd = mm[win.a];
    end
    if (!h_req || who == 2) wcnt = 0;
    else if (hp && wcnt < MAX_WAIT) wcnt++;
    @(negedge clk);
  endtask

  initial begin
    int grant_k;
    rst = 1'b0;
    i2c_req = 1'b0; i2c_we = 1'b0; i2c_addr = '0; i2c_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      mem[i] <= v;
      mm[i] = v;
    end
    mem[7] <= 8'h3C;  mm[7] = 8'h3C;
    mem[31] <= 8'h11; mm[31] = 8'h11;
    model_reset();
    ack_was = 1'b0;
    #1;
    chk("rst_rvalid", 32'(i2c_rvalid), 0);
    chk("rst_rdata", 32'(i2c_rdata), 0);
    chk("rst_ovf", 32'(i2c_ovf), 0);
    chk("rst_ack", 32'(h_ack), 0);
    chk("rst_hrdata", 32'(h_rdata), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // I2C write 3=A5, then read it back
    i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 5'd3; i2c_wdata = 8'hA5;
    step();
    i2c_req = 1'b0;
    step();
    i2c_req = 1'b1; i2c_we = 1'b0; i2c_addr = 5'd3; i2c_wdata = 8'h00;
    step();
    i2c_req = 1'b0;
    chk("t1_rvalid", 32'(i2c_rvalid), 1);
    chk("t1_rdata", 32'(i2c_rdata), 32'h A5);
    step();

    // Host read of preloaded address on an idle bus
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd7; h_wdata = 8'h00;
    step();
    chk("t2_ack", 32'(h_ack), 1);
    chk("t2_rdata", 32'(h_rdata), 32'h3C);
    step();
    chk("t2_ack_once", 32'(h_ack), 0);
    h_req = 1'b0;
    step();

    // Same-cycle contention: I2C write 9=5A wins, host read of 9 follows
    i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 5'd9; i2c_wdata = 8'h5A;
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd9;
    step();
    chk("t3_host_waits", 32'(h_ack), 0);
    i2c_req = 1'b0;
    step();
    chk("t3_ack", 32'(h_ack), 1);
    chk("t3_rdata", 32'(h_rdata), 32'h5A);
    step();
    h_req = 1'b0;
    step();

    // Continuous I2C writes with a held host request: starvation override, then overflow
    grant_k = -1;
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd12; h_wdata = 8'h00;
    for (int k = 0; k < 12; k++) begin
      i2c_req = 1'b1; i2c_we = 1'b1;
      i2c_addr = AW'(10 + (k % 4)); i2c_wdata = DW'($urandom);
      if (k == 10) begin
        i2c_addr = 5'd31; i2c_wdata = 8'hEE;
      end
      if (k == 6) begin
        h_we = 1'b1; h_addr = 5'd20; h_wdata = 8'h77;
      end
      step();
      if (h_ack && grant_k < 0) grant_k = k;
      if (k == 8) chk("t4_no_ovf", 32'(i2c_ovf), 0);
    end
    chk("t4_host_grant_cycle", 32'(grant_k), 32'(MAX_WAIT));
    chk("t5_ovf_set", 32'(i2c_ovf), 1);
    i2c_req = 1'b0;
    h_req = 1'b0;
    step();
    chk("t5_ovf_sticky", 32'(i2c_ovf), 1);
    chk("t5_dropped_not_written", 32'(mem[31]), 32'h11);

    // Async reset with a buffered entry pending: make the slot full first
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd1;
    for (int k = 0; k < 5; k++) begin
      i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 5'd14; i2c_wdata = DW'(k);
      step();
    end
    chk("t6_buffered_before_rst", 32'(bq.size()), 1);
    i2c_req = 1'b0;
    h_req = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_rvalid", 32'(i2c_rvalid), 0);
    chk("t6_rst_rdata", 32'(i2c_rdata), 0);
    chk("t6_rst_ovf", 32'(i2c_ovf), 0);
    chk("t6_rst_ack", 32'(h_ack), 0);
    chk("t6_rst_hrdata", 32'(h_rdata), 0);
    chk("t6_rst_ram_we", 32'(ram_we), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // Random traffic with a protocol-abiding host
    for (int n = 0; n < 3000; n++) begin
      i2c_req   = ($urandom_range(0, 1) == 1);
      i2c_we    = ($urandom_range(0, 1) == 1);
      i2c_addr  = AW'($urandom_range(0, 7));
      i2c_wdata = DW'($urandom);
      if (h_req && ack_was) begin
        if ($urandom_range(0, 1) == 1) h_req = 1'b0;
        h_we = ($urandom_range(0, 1) == 1);
        h_addr = AW'($urandom_range(0, 7));
        h_wdata = DW'($urandom);
      end else if (!h_req && $urandom_range(0, 2) == 0) begin
        h_req = 1'b1;
        h_we = ($urandom_range(0, 1) == 1);
        h_addr = AW'($urandom_range(0, 7));
        h_wdata = DW'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
